// File: rtl/keypad_scanner.sv
// Row/column matrix keypad scanner with per-key debouncing over scan frames.
// Debounced changes are reported one at a time through a single-entry valid/ready slot.
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter bit COL_WHEN_IDLE  = 1'b1,
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [ROWS-1:0]               row_out,
    input  logic [COLS-1:0]               col_in,
    output logic [ROWS*COLS-1:0]          key_state,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic [$clog2(ROWS*COLS)-1:0]  event_key,
    output logic                          event_press
);

    localparam int KEYS = ROWS * COLS;
    localparam int KW   = $clog2(KEYS);
    localparam int RW   = $clog2(ROWS);
    localparam int CLW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW   = $clog2(SETTLE_CYCLES);
    localparam int CW   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [ROWS-1:0] ROW_IDLE    = {ROWS{COL_WHEN_IDLE}};
    localparam logic [ROWS-1:0] ROW_ONE     = ROWS'(1);
    localparam logic [RW-1:0]   ROW_ZERO    = RW'(0);
    localparam logic [RW-1:0]   ROW_INC     = RW'(1);
    localparam logic [RW-1:0]   LAST_ROW    = RW'(ROWS - 1);
    localparam logic [CLW-1:0]  COL_ZERO    = CLW'(0);
    localparam logic [CLW-1:0]  COL_INC     = CLW'(1);
    localparam logic [CLW-1:0]  LAST_COL    = CLW'(COLS - 1);
    localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0]   SETTLE_ZERO = SW'(0);
    localparam logic [SW-1:0]   SETTLE_DEC  = SW'(1);
    localparam logic [CW-1:0]   CNT_ZERO    = CW'(0);
    localparam logic [CW-1:0]   CNT_INC     = CW'(1);
    localparam logic [CW-1:0]   CNT_MAX     = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [KW-1:0]   KEY_ZERO    = KW'(0);

    typedef enum logic [1:0] {
        ST_DRIVE  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_EVAL   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [RW-1:0]   row_r;
    logic [CLW-1:0]  col_r;
    logic [SW-1:0]   settle_r;
    logic [COLS-1:0] sync1_r;
    logic [COLS-1:0] sync2_r;
    logic [COLS-1:0] sample_r;
    logic [CW-1:0]   cnt_r [KEYS];

    logic [COLS-1:0] raw_s;
    logic [ROWS-1:0] drive_s;
    logic [KW-1:0]   key_idx_s;
    logic            sample_bit_s;
    logic            differ_s;
    logic            cnt_below_s;
    logic            change_s;
    logic            slot_free_s;
    logic            stall_s;
    logic            load_s;

    // Datapath decode: current key, debounce decision and slot arbitration.
    always_comb begin
        raw_s        = sync2_r ^ {COLS{COL_WHEN_IDLE}};
        drive_s      = ROW_IDLE ^ (ROW_ONE << row_r);
        key_idx_s    = KW'((32'(row_r) * 32'(COLS)) + 32'(col_r));
        sample_bit_s = sample_r[col_r];
        differ_s     = (sample_bit_s != key_state[key_idx_s]);
        cnt_below_s  = (cnt_r[key_idx_s] < CNT_MAX);
        change_s     = (state_r == ST_EVAL) && differ_s && !cnt_below_s;
        slot_free_s  = !event_valid || event_ready;
        stall_s      = change_s && !slot_free_s;
        load_s       = change_s && slot_free_s;
    end

    // Scan FSM next-state logic; EVAL holds its column while the event slot is blocked.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_DRIVE: begin
                state_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_r == SETTLE_ZERO) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                state_s = ST_EVAL;
            end
            ST_EVAL: begin
                if (!stall_s && (col_r == LAST_COL)) begin
                    state_s = ST_DRIVE;
                end else begin
                    state_s = ST_EVAL;
                end
            end
            default: begin
                state_s = ST_DRIVE;
            end
        endcase
    end

    // State register, synchronizer, scan counters, debounce state and event slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_DRIVE;
            row_r       <= ROW_ZERO;
            col_r       <= COL_ZERO;
            settle_r    <= SETTLE_ZERO;
            sync1_r     <= {COLS{COL_WHEN_IDLE}};
            sync2_r     <= {COLS{COL_WHEN_IDLE}};
            sample_r    <= {COLS{1'b0}};
            row_out     <= ROW_IDLE;
            key_state   <= {KEYS{1'b0}};
            event_valid <= 1'b0;
            event_key   <= KEY_ZERO;
            event_press <= 1'b0;
            for (int i = 0; i < KEYS; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            state_r <= state_s;
            sync1_r <= col_in;
            sync2_r <= sync1_r;
            case (state_r)
                ST_DRIVE: begin
                    row_out  <= drive_s;
                    settle_r <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    settle_r <= settle_r - SETTLE_DEC;
                end
                ST_SAMPLE: begin
                    sample_r <= raw_s;
                    col_r    <= COL_ZERO;
                end
                ST_EVAL: begin
                    if (!stall_s) begin
                        if (!differ_s) begin
                            cnt_r[key_idx_s] <= CNT_ZERO;
                        end else if (cnt_below_s) begin
                            cnt_r[key_idx_s] <= cnt_r[key_idx_s] + CNT_INC;
                        end else begin
                            key_state[key_idx_s] <= sample_bit_s;
                            cnt_r[key_idx_s]     <= CNT_ZERO;
                        end
                        if (col_r == LAST_COL) begin
                            col_r <= COL_ZERO;
                            row_r <= (row_r == LAST_ROW) ? ROW_ZERO : (row_r + ROW_INC);
                        end else begin
                            col_r <= col_r + COL_INC;
                        end
                    end
                end
                default: begin
                    row_out <= ROW_IDLE;
                end
            endcase
            // A load on the accepting edge keeps valid high with the new contents.
            if (load_s) begin
                event_valid <= 1'b1;
                event_key   <= key_idx_s;
                event_press <= sample_bit_s;
            end else if (event_ready) begin
                event_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives col_in from row_out,
// expected events are queued with their handshake cycle and checked by a monitor.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [15:0] key_state;
    logic        event_valid;
    logic        event_ready;
    logic [3:0]  event_key;
    logic        event_press;

    logic [15:0] keys;
    int          cyc;
    int          tests;
    int          fails;

    typedef struct {
        int key;
        bit press;
        int when;
    } exp_t;

    exp_t        sb_q[$];
    logic        hold_v;
    logic [3:0]  hold_key;
    logic        hold_press;

    keypad_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .row_out     (row_out),
        .col_in      (col_in),
        .key_state   (key_state),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_key   (event_key),
        .event_press (event_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pull-up keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if ((row_out[r] == 1'b0) && keys[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    // Cycle count since the last reset release; sample index j is seen with cyc = j+1.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while ((cyc != n) && (guard < 20000)) begin
            step();
            guard++;
        end
        if (cyc != n) begin
            tests++;
            fails++;
            $display("FAIL wait_cyc: actual %0d required %0d", cyc, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_out"},     32'(row_out),     32'hF);
        check({tag, "_key_state"},   32'(key_state),   32'h0);
        check({tag, "_event_valid"}, 32'(event_valid), 32'h0);
        check({tag, "_event_key"},   32'(event_key),   32'h0);
        check({tag, "_event_press"}, 32'(event_press), 32'h0);
    endtask

    task automatic push(input int key, input bit press, input int when);
        exp_t e;
        e.key   = key;
        e.press = press;
        e.when  = when;
        sb_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks held slot stability.
    always @(negedge clk) begin
        if (event_valid && hold_v) begin
            check("hold_key",   32'(event_key),   32'(hold_key));
            check("hold_press", 32'(event_press), 32'(hold_press));
        end
        hold_v     <= event_valid && !event_ready && !rst;
        hold_key   <= event_key;
        hold_press <= event_press;
        if (event_valid && event_ready && !rst) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: actual key %0d press %0d required none (cyc %0d)",
                         event_key, event_press, cyc);
            end else begin
                check("event_key",   32'(event_key),   32'(sb_q[0].key));
                check("event_press", 32'(event_press), 32'(sb_q[0].press));
                check("event_cycle", 32'(cyc),         32'(sb_q[0].when));
                sb_q.delete(0);
            end
        end
    end

    initial begin
        logic [3:0] row_pat [4];
        row_pat[0] = 4'b1110;
        row_pat[1] = 4'b1101;
        row_pat[2] = 4'b1011;
        row_pat[3] = 4'b0111;
        tests       = 0;
        fails       = 0;
        hold_v      = 1'b0;
        rst         = 1'b1;
        event_ready = 1'b1;
        keys        = 16'h0000;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle for 10 frames: rows rotate every 22 cycles, no events.
        for (int k = 1; k <= 880; k++) begin
            wait_cyc(k);
            check("idle_row_out", 32'(row_out), 32'(row_pat[((k-1)/22)%4]));
        end
        check("idle_key_state", 32'(key_state), 32'h0);
        check("idle_valid", 32'(event_valid), 32'h0);

        // Key 6 press from frame 10, reported in frame 13; release from frame 15.
        keys = 16'h0040;
        push(6, 1'b1, 88*13 + 43);
        wait_cyc(88*13 + 43);
        check("press6_key_state", 32'(key_state), 32'h0040);
        step();
        check("press6_valid_drop", 32'(event_valid), 32'h0);
        wait_cyc(88*15);
        keys = 16'h0000;
        push(6, 1'b0, 88*18 + 43);
        wait_cyc(88*18 + 44);
        check("release6_key_state", 32'(key_state), 32'h0);

        // Bounce: 3 frames pressed, 1 released, five times.
        for (int i = 0; i < 5; i++) begin
            wait_cyc(88*20 + 352*i);
            keys = 16'h0040;
            wait_cyc(88*20 + 352*i + 264);
            keys = 16'h0000;
        end
        wait_cyc(88*40);
        check("bounce_key_state", 32'(key_state), 32'h0);

        // Streaming: keys 0..3 in one frame give four back-to-back events.
        wait_cyc(88*41);
        keys = 16'h000F;
        for (int c = 0; c < 4; c++) push(c, 1'b1, 88*44 + 19 + c);
        wait_cyc(88*44 + 22);
        check("stream_key_state", 32'(key_state), 32'h000F);
        wait_cyc(88*46);
        keys = 16'h0000;
        for (int c = 0; c < 4; c++) push(c, 1'b0, 88*49 + 19 + c);

        // Backpressure: key 0 held in the slot, scan stalls at key 3.
        wait_cyc(88*50);
        event_ready = 1'b0;
        keys        = 16'h0009;
        wait_cyc(88*53 + 19 + 2 + 50);
        check("stall_row_out", 32'(row_out), 32'hE);
        check("stall_valid", 32'(event_valid), 32'h1);
        check("stall_key_state", 32'(key_state), 32'h0001);
        push(0, 1'b1, cyc);
        event_ready = 1'b1;
        step();
        event_ready = 1'b0;
        check("resume_valid", 32'(event_valid), 32'h1);
        check("resume_key", 32'(event_key), 32'h3);
        check("resume_press", 32'(event_press), 32'h1);
        check("resume_key_state", 32'(key_state), 32'h0009);
        step();
        check("resume_row_out", 32'(row_out), 32'hD);

        // Reset with key 3 pending, then reset again mid-stall.
        step();
        rst = 1'b1;
        step();
        check("rst1_cyc", 32'(cyc), 32'h0);
        check_reset_outputs("rst_pending");
        rst = 1'b0;
        wait_cyc(300);
        check("stall2_valid", 32'(event_valid), 32'h1);
        check("stall2_key", 32'(event_key), 32'h0);
        check("stall2_row_out", 32'(row_out), 32'hE);
        rst = 1'b1;
        step();
        check_reset_outputs("rst_stall");
        rst         = 1'b0;
        event_ready = 1'b1;
        push(0, 1'b1, 88*3 + 19);
        push(3, 1'b1, 88*3 + 22);
        wait_cyc(88*4);
        keys = 16'h0000;
        push(0, 1'b0, 88*7 + 19);
        push(3, 1'b0, 88*7 + 22);
        wait_cyc(700);
        check("final_key_state", 32'(key_state), 32'h0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Row/column matrix keypad controller with per-key debouncing. It drives one row at a time and waits a settle interval. It then samples the synchronized column lines and debounces each key over consecutive scan frames. Debounced press and release changes are reported as single events over a valid/ready handshake, and a parallel debounced state vector is also provided. It sits between the keypad pins and user logic, and replaces per-button debouncers where many keys share few pins.

## Interface
- `ROWS`, 4: number of driven rows, ≥2.
- `COLS`, 4: number of sampled columns, ≥1.
- `COL_WHEN_IDLE`, 1: column level with no key pressed (1 = pull-ups, active-low scanning).
- `SETTLE_CYCLES`, 16: cycles between row drive and sample, ≥3; this covers the 2-stage synchronizer.
- `DEBOUNCE_SCANS`, 4: consecutive differing frames before a key changes state, ≥1.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `row_out` out ROWS: active row driven to `~COL_WHEN_IDLE`, all others to `COL_WHEN_IDLE`.
- `col_in` in COLS: raw asynchronous column inputs.
- `key_state` out ROWS*COLS: debounced state, 1 = pressed; bit k = row*COLS + col.
- `event_valid` out 1: event pending.
- `event_ready` in 1: consumer accepts the event.
- `event_key` out $clog2(ROWS*COLS): index of the changed key.
- `event_press` out 1: 1 = press, 0 = release.

## Operation
- Column sync: 2 flops per column, reset to `COL_WHEN_IDLE`. `raw[c] = sync[c] ^ COL_WHEN_IDLE`, so 1 = pressed.
- FSM states and transitions:
  - DRIVE: drive `row_out` for row r, load `settle_cnt = SETTLE_CYCLES-1`, go to SETTLE.
  - SETTLE: decrement `settle_cnt`; at 0, go to SAMPLE.
  - SAMPLE: latch `raw` into `sample`, set c = 0, go to EVAL.
  - EVAL: process column c, one column per cycle (rules below).
  - After column COLS-1: r = (r+1) mod ROWS, go to DRIVE. Row ROWS-1 wraps to 0.
- Per-key EVAL, k = r*COLS + c, with counter `cnt[k]` of width $clog2(DEBOUNCE_SCANS+1):
  - If `sample[c] == key_state[k]`: `cnt[k] <= 0`.
  - Else if `cnt[k] < DEBOUNCE_SCANS-1`: `cnt[k] <= cnt[k]+1`.
  - Else it is a change: `key_state[k] <= sample[c]`, `cnt[k] <= 0`, and an event {k, sample[c]} is emitted.
- Event slot is a single registered entry.
  - A change may load the slot when `!event_valid || event_ready`. The same-edge accept-and-load keeps `event_valid` high with the new contents.
  - If the slot is blocked, the FSM stalls in EVAL at the same c. `key_state`, `cnt`, `row_out` and `sample` are frozen until the slot frees.
  - Non-change columns never stall.
- `event_valid` falls on the edge after acceptance unless a new event is loaded on that edge.
- `event_key` and `event_press` are stable while `event_valid` is high.
- At most one event per cycle. Events are emitted in scan order.
- Ghosting and masking with ≥3 keys pressed is not resolved; those keys are reported as sampled.

## Timing
- Reset values: `row_out` all `COL_WHEN_IDLE`, `key_state` 0, all `cnt` 0, `event_valid` 0, `event_key` 0, `event_press` 0, FSM in DRIVE with r = 0.
- First row is driven one cycle after `rst` deasserts.
- Unstalled row period: 1 + SETTLE_CYCLES + 1 + COLS cycles. Defaults give 22 cycles per row and 88 per frame.
- Press latency: a press stable from frame f is reported in frame f+DEBOUNCE_SCANS-1. `event_valid` rises on the edge ending that key's EVAL cycle.
- `key_state[k]` updates on the same edge as the event load.
- Reset mid-stall or mid-scan discards the pending event, debounced state and counters. No event is emitted for the discarded state.
- `DEBOUNCE_SCANS = 1` reports a change on the first differing frame.

## Test plan
- Idle, defaults, `col_in` = 4'b1111 for 10 frames → no `event_valid`, `key_state` = 0. `row_out` sequences 1110, 1101, 1011, 0111, each for 22 cycles.
- Press key 6: `col_in[2]` = 0 whenever `row_out[1]` = 0 → exactly one event {key 6, press 1} in the 4th frame, `key_state[6]` = 1. Releasing gives exactly one {6, 0} four frames later.
- Bounce: key 6 pressed for 3 frames, released for 1, repeated 5 times → no event, `key_state[6]` stays 0.
- Backpressure: keys 0 and 3 pressed together, `event_ready` = 0 → {0, 1} is held. FSM stalls in EVAL at c = 3 with `row_out` = 1110. Raise `event_ready` for one cycle after 50 cycles → next cycle shows `event_valid` = 1 with {3, 1}, and scanning resumes.
- Streaming: `event_ready` held at 1 while keys 0–3 are pressed in the same frame → 4 consecutive cycles of events with keys 0, 1, 2, 3.
- Reset mid-stall: assert `rst` for 1 cycle during the backpressure scenario → all outputs at reset values on the next cycle. Held keys are re-reported after DEBOUNCE_SCANS frames.
